// File: rtl/mem_dump_pkg.sv
// Shared debug-unit definitions for the data-memory dump sequencer:
// state encoding, read-latency bounds and debug-select polarities.
package mem_dump_pkg;

  localparam int DEFAULT_ADDRWIDTH = 32;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int NB_LAT     = $clog2(RD_LAT_MAX + 1);

  localparam logic DBG_SEL_MEM   = 1'b0;
  localparam logic DBG_SEL_DEBUG = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HALT_WAIT = 3'd1,
    ST_RD        = 3'd2,
    ST_LAT_WAIT  = 3'd3,
    ST_CHECK     = 3'd4,
    ST_SEND      = 3'd5,
    ST_NEXT      = 3'd6,
    ST_DONE      = 3'd7
  } dump_state_t;

  function automatic int clamp_rd_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mem_dump_ctrl_word_serializer.sv
// Holds one captured memory word and streams it MSB-first as bytes
// over a valid/ready handshake.
module word_serializer #(
  parameter  int NB_DATA  = 32,
  localparam int NB_BYTES = NB_DATA / 8,
  localparam int NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_start,
  input  logic               i_flush,
  input  logic               i_ready,
  output logic [7:0]         o_data,
  output logic               o_valid,
  output logic               o_last,
  output logic               o_accept
);

  logic [NB_DATA-1:0] r_word;
  logic [NB_IDX-1:0]  r_idx;
  logic               r_valid;
  logic               w_last_idx;
  logic               w_accept;

  assign w_last_idx = (r_idx == NB_IDX'(NB_BYTES - 1));
  assign w_accept   = r_valid & i_ready;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_word  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_load) r_word <= i_word;
      if (i_flush) begin
        r_valid <= 1'b0;
        r_idx   <= '0;
      end else if (i_start) begin
        r_valid <= 1'b1;
        r_idx   <= '0;
      end else if (w_accept) begin
        if (w_last_idx) begin
          r_valid <= 1'b0;
          r_idx   <= '0;
        end else begin
          r_idx <= r_idx + NB_IDX'(1);
        end
      end
    end
  end

  // Byte 0 is the most significant byte of the word.
  always_comb begin
    o_data = r_word[(NB_BYTES - 1 - int'(r_idx)) * 8 +: 8];
  end

  assign o_valid  = r_valid;
  assign o_last   = r_valid & w_last_idx;
  assign o_accept = w_accept;

endmodule

// File: rtl/mem_dump_ctrl.sv
// Debug sequencer that takes over the MEM stage data memory once the
// pipeline is halted and streams every (optionally dirty) word to the UART.
module mem_dump_ctrl
  import mem_dump_pkg::*;
#(
  parameter int NB_DATA   = 32,
  parameter int NB_ADDR   = DEFAULT_ADDRWIDTH,
  parameter int MEM_WORDS = 32,
  parameter int ADDR_STEP = 4,
  parameter int RD_LAT    = 1
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               dirty_only_i,
  input  logic               halted_i,
  output logic               hold_req_o,
  output logic [NB_ADDR-1:0] dbg_addr_o,
  output logic               dbg_addr_sel_o,
  output logic               dbg_rd_sel_o,
  input  logic [NB_DATA-1:0] rd_data_i,
  input  logic               dirty_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [NB_ADDR-1:0] words_sent_o
);

  localparam int LAT     = clamp_rd_lat(RD_LAT);
  localparam int NB_WIDX = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  dump_state_t        r_state;
  dump_state_t        w_next;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_ADDR-1:0] r_words_sent;
  logic [NB_WIDX-1:0] r_word_idx;
  logic [NB_LAT-1:0]  r_lat;
  logic               r_dirty_only;
  logic               r_dirty_flag;
  logic               r_active;
  logic               r_addr_sel;
  logic               r_rd_sel;
  logic               r_done;

  logic               w_abort;
  logic               w_capture;
  logic               w_send_start;
  logic               w_word_sent;
  logic               w_tx_accept;
  logic               w_tx_last;
  logic               w_tx_valid;
  logic [7:0]         w_tx_data;

  assign w_word_sent = (r_state == ST_SEND) & w_tx_accept & w_tx_last;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Losing halted_i while the debug path owns the memory aborts the dump.
  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      ST_IDLE:      if (start_i) w_next = ST_HALT_WAIT;
      ST_HALT_WAIT: if (halted_i) w_next = ST_RD;
      ST_RD:        w_next = ST_LAT_WAIT;
      ST_LAT_WAIT:  if (r_lat == NB_LAT'(1)) w_next = ST_CHECK;
      ST_CHECK:     w_next = (r_dirty_only && !r_dirty_flag) ? ST_NEXT : ST_SEND;
      ST_SEND:      if (w_word_sent) w_next = ST_NEXT;
      ST_NEXT:      w_next = (r_word_idx == NB_WIDX'(MEM_WORDS - 1)) ? ST_DONE : ST_RD;
      ST_DONE:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
    if ((r_state inside {ST_RD, ST_LAT_WAIT, ST_CHECK, ST_SEND, ST_NEXT}) && !halted_i) begin
      w_abort = 1'b1;
      w_next  = ST_IDLE;
    end
  end

  assign w_capture    = (r_state == ST_LAT_WAIT) && (w_next == ST_CHECK);
  assign w_send_start = (r_state == ST_CHECK) && (w_next == ST_SEND);

  // The latency counter spends exactly LAT cycles in LAT_WAIT.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_addr       <= '0;
      r_words_sent <= '0;
      r_word_idx   <= '0;
      r_lat        <= '0;
      r_dirty_only <= 1'b0;
      r_dirty_flag <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start_i) begin
        r_dirty_only <= dirty_only_i;
        r_words_sent <= '0;
        r_addr       <= '0;
        r_word_idx   <= '0;
      end
      if (r_state == ST_RD)
        r_lat <= NB_LAT'(LAT);
      else if (r_state == ST_LAT_WAIT)
        r_lat <= r_lat - NB_LAT'(1);
      if (w_capture) r_dirty_flag <= dirty_i;
      if (w_word_sent) r_words_sent <= r_words_sent + NB_ADDR'(1);
      if (r_state == ST_NEXT && w_next == ST_RD) begin
        r_addr     <= r_addr + NB_ADDR'(ADDR_STEP);
        r_word_idx <= r_word_idx + NB_WIDX'(1);
      end
    end
  end

  // Control outputs are decoded from the next state so they are registered.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_active   <= 1'b0;
      r_addr_sel <= DBG_SEL_MEM;
      r_rd_sel   <= DBG_SEL_MEM;
      r_done     <= 1'b0;
    end else begin
      r_active   <= w_next inside {ST_HALT_WAIT, ST_RD, ST_LAT_WAIT, ST_CHECK, ST_SEND, ST_NEXT};
      r_addr_sel <= (w_next inside {ST_RD, ST_LAT_WAIT, ST_CHECK, ST_SEND, ST_NEXT}) ? DBG_SEL_DEBUG : DBG_SEL_MEM;
      r_rd_sel   <= (w_next inside {ST_RD, ST_LAT_WAIT, ST_CHECK, ST_SEND, ST_NEXT}) ? DBG_SEL_DEBUG : DBG_SEL_MEM;
      r_done     <= (w_next == ST_DONE);
    end
  end

  word_serializer #(
    .NB_DATA (NB_DATA)
  ) u_serializer (
    .i_clock   (clock_i),
    .i_reset_n (reset_i),
    .i_load    (w_capture),
    .i_word    (rd_data_i),
    .i_start   (w_send_start),
    .i_flush   (w_abort),
    .i_ready   (tx_ready_i),
    .o_data    (w_tx_data),
    .o_valid   (w_tx_valid),
    .o_last    (w_tx_last),
    .o_accept  (w_tx_accept)
  );

  assign hold_req_o     = r_active;
  assign busy_o         = r_active;
  assign dbg_addr_o     = r_addr;
  assign dbg_addr_sel_o = r_addr_sel;
  assign dbg_rd_sel_o   = r_rd_sel;
  assign tx_data_o      = w_tx_data;
  assign tx_valid_o     = w_tx_valid;
  assign done_o         = r_done;
  assign words_sent_o   = r_words_sent;

endmodule

// File: doc/mem_dump_ctrl.md
# mem_dump_ctrl

Debug sequencer for the MEM stage data memory. Once the pipeline is halted, it takes ownership of the data memory through the MEM stage debug muxes and walks the address space. Each word is read with the forced signed-word debug read, optionally skipped when the dirty bit is clear, and serialized MSB-first as four bytes onto a byte-wide valid/ready stream toward the debug UART TX. It sits between the debug unit FSM (start/done), the pipeline hold logic, the MEM stage debug inputs and the UART TX.

## Interface
Parameters:
- NB_DATA, 32, memory word width; must be a multiple of 8.
- NB_ADDR, `ADDRWIDTH (from parameters.vh), memory address width.
- MEM_WORDS, 32, number of words to dump.
- ADDR_STEP, 4, address increment per word (byte addressing).
- RD_LAT, 1, cycles from address valid to stable read data (1..3).

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle request to begin a dump; ignored unless IDLE.
- dirty_only_i  in  1  sampled at start; 1 = skip words whose dirty_i is 0.
- halted_i  in  1  pipeline is frozen; no MEM stage access in flight.
- hold_req_o  out  1  request that the pipeline freeze; high from accepted start until DONE.
- dbg_addr_o  out  NB_ADDR  address driven into the MEM stage debug address input.
- dbg_addr_sel_o  out  1  1 = the debug address owns the memory address mux.
- dbg_rd_sel_o  out  1  1 = forced debug read control (signed word read, write disabled).
- rd_data_i  in  NB_DATA  memory read data from the MEM stage debug output.
- dirty_i  in  1  dirty bit for the currently addressed word.
- tx_data_o  out  8  byte to transmit.
- tx_valid_o  out  1  tx_data_o is valid; held until accepted.
- tx_ready_i  in  1  sink accepts the byte when valid & ready.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at dump completion.
- words_sent_o  out  NB_ADDR  words transmitted in the current or last dump.

## Operation
- Reset (async, reset_i=0): state IDLE. All outputs are 0, including dbg_addr_o, words_sent_o and tx_data_o. All counters are cleared.
- States: IDLE, HALT_WAIT, RD, LAT_WAIT, CHECK, SEND, NEXT, DONE.
- IDLE:
  - start_i=1 latches dirty_only_i, clears words_sent_o and the address counter, sets hold_req_o=1, and moves to HALT_WAIT.
- HALT_WAIT:
  - The block stays here until halted_i=1, then moves to RD.
  - dbg_addr_sel_o and dbg_rd_sel_o stay 0 until halted_i is seen.
- RD:
  - dbg_addr_sel_o=dbg_rd_sel_o=1, and the latency counter is loaded with RD_LAT.
  - Both select outputs stay 1 through CHECK, SEND and NEXT.
- LAT_WAIT: decrement the latency counter; at 0, capture rd_data_i and dirty_i into the shift register and flag, then go to CHECK.
- CHECK:
  - If dirty_only=1 and the captured dirty flag is 0, go to NEXT.
  - Otherwise go to SEND with the byte index at 0.
- SEND:
  - tx_data_o = captured word byte [NB_DATA-1-8*idx -: 8]; tx_valid_o=1.
  - On valid & ready, idx increments. After the last byte is accepted, words_sent_o increments and the state moves to NEXT.
  - tx_data_o and tx_valid_o must not change while valid=1 and ready=0.
- NEXT:
  - If the word index equals MEM_WORDS-1, go to DONE.
  - Otherwise dbg_addr_o += ADDR_STEP, the word index increments, and the state moves to RD.
- DONE: done_o=1 for one cycle; hold_req_o, both selects and busy_o drop in the same cycle; next state is IDLE.
- halted_i falling mid-dump is a protocol error: the block aborts to IDLE, deasserts all selects and hold_req_o, and does not pulse done_o.
- start_i while busy is ignored.
- Address arithmetic is modulo 2^NB_ADDR; the final address is (MEM_WORDS-1)*ADDR_STEP.

## Timing
- Latency from start to hold_req_o: 1 cycle.
- From halted_i high to the first selects high: 1 cycle (RD).
- Per word: 1 (RD) + RD_LAT (LAT_WAIT) + 1 (CHECK) + (4 × handshake cycles) + 1 (NEXT).
  - The minimum with tx_ready_i tied high and RD_LAT=1 is 8 cycles per word.
  - A skipped word takes 4 cycles.
- rd_data_i is sampled exactly RD_LAT cycles after dbg_addr_o/dbg_addr_sel_o became valid.
- words_sent_o holds its value after DONE until the next accepted start.
- All outputs are registered. The only exception is tx_data_o, which is a mux of registered state.

## Structure
- State encoding, RD_LAT bounds and the debug-select polarity constants go in a shared debug-unit package header next to parameters.vh.
- One sub-module is natural: word_serializer. It takes a NB_DATA word plus a load strobe and emits the byte stream with valid/ready, the byte index and a last flag.
- The FSM, address counter, latency counter and word counter live in mem_dump_ctrl.

## Test plan
- Full dump, ready tied 1, MEM_WORDS=4, RD_LAT=1:
  - Memory holds 0x11223344, 0xAABBCCDD, 0, 0xFFFFFFFF.
  - Bytes observed: 11 22 33 44 AA BB CC DD 00 00 00 00 FF FF FF FF.
  - words_sent_o=4; done_o pulses once, 32 cycles after the first RD.
- dirty_only_i=1 with dirty_i=1 only at address 8: exactly 4 bytes are sent (word at 8), words_sent_o=1, and dbg_addr_o reaches 12 before DONE.
- Backpressure: tx_ready_i toggles 0/1 every cycle; tx_data_o stays stable while stalled and no byte is dropped or duplicated.
- halted_i held 0 for 10 cycles after start: selects stay 0, hold_req_o=1 throughout, and RD is entered 1 cycle after halted_i rises.
- halted_i drops during SEND of word 2: the block goes to IDLE next cycle, hold_req_o=0, no done_o, and start_i 3 cycles later begins a fresh dump at address 0.
- reset_i asserted mid-SEND: all outputs are 0 immediately (async), and start_i applied during the dump is ignored with no restart.
